xor_serial_sched: RTL
=====================

// Module: xor_serial_sched
// PURPOSE
//  Shares one gate-level 1-bit XOR cell among NREQ requesters. Round-robin arbitrates
//  requests, latches the winner's two W-bit operands, and streams them LSB-first
//  through the shared cell, one bit per cycle. Returns a W-bit result, the requester
//  id and the result parity. Sits between switch/gate-level XOR cells and the bench/SoC logic.
// PARAMETERS
//  W     8  operand/result width in bits (2..32)
//  NREQ  4  number of requesters (2..8); IDW = $clog2(NREQ)
// PORTS
//  clk     in   1         single clock, rising edge
//  rst_n   in   1         synchronous, active-low reset
//  req     in   NREQ      request per requester, level
//  a_in    in   NREQ*W    operand A; requester i at [i*W +: W]
//  b_in    in   NREQ*W    operand B; requester i at [i*W +: W]
//  gnt     out  NREQ      one-hot grant, held from LOAD through DONE
//  busy    out  1         1 in LOAD/SHIFT/DONE
//  done    out  1         1-cycle pulse when res/res_id/parity update
//  res     out  W         A^B of the last completed operation, held until next done
//  res_id  out  IDW       index of the requester that owns res
//  parity  out  1         ^res (XOR-reduction), updated with res
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, gnt=0, busy=0, done=0, res=0, res_id=0,
//    parity=0, bit counter=0, RR pointer=NREQ-1 (req[0] has top priority next).
//    Reset mid-operation aborts it immediately. No partial result is published.
//  - FSM states are IDLE, LOAD, SHIFT and DONE:
//    IDLE : if |req, pick the first set req[] searching from ptr+1 (mod NREQ) -> LOAD.
//           Otherwise stay in IDLE.
//    LOAD : gnt[win]=1. Latch a_in/b_in slices of win and clear the shift register.
//           Set ptr=win -> SHIFT.
//    SHIFT: W cycles, bit k=0..W-1. Shared cell computes a_q[k]^b_q[k].
//           The result shifts in MSB-first so res bit k lands at position k.
//           After cycle W-1 -> DONE.
//    DONE : done=1 for 1 cycle. Publish res, res_id=win and parity=^res.
//           Drop gnt -> IDLE.
//  - Latency: req seen in IDLE at cycle 0; LOAD at cycle 1; SHIFT at cycles 2..W+1;
//    done at cycle W+2. Minimum period between grants is W+3 cycles (one IDLE cycle between ops).
//  - Operands must be stable in the LOAD cycle, i.e. the first cycle gnt is high.
//    After that they are don't-care.
//  - If req drops after the grant, the operation still completes.
//    Changes to req during busy are ignored until IDLE.
//  - Simultaneous requests are served in strict round-robin. With all requests held
//    continuously, grant order is 0,1,...,NREQ-1,0.
//  - gnt is always one-hot or zero. busy==|gnt.
// CONFIGURATION
//  XOR_SCHED_STATS_EN defined:
//   - adds output port ops_done[15:0], reset to 0.
//   - ops_done increments on each done pulse and wraps from 16'hFFFF to 0.
//  XOR_SCHED_STATS_EN undefined: no port, no counter. All other behaviour is identical.
// STRUCTURE
//  - Package xor_sched_pkg holds the state encoding localparams
//    (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3) and the IDW helper function.
//  - Sub-module xor_bit_cell(y,a,b) is the shared 1-bit XOR, built from four 2-input
//    NAND gate primitives. Exactly one instance exists.
//  - Top level contains the RR arbiter, FSM, operand regs, bit counter, shift reg and output regs.
// TESTING  (W=8, NREQ=4)
//  1 rst_n=0 for 2 cycles with req=4'hF -> gnt=0, busy=0, done=0, res=0, res_id=0, parity=0.
//  2 req=4'b0010, A1=8'hA5, B1=8'h0F -> gnt=4'b0010 on cycles 1..10.
//    done at cycle 10 with res=8'hAA, res_id=1, parity=0.
//  3 req=4'hF held, distinct operands -> grants in order 0,1,2,3,0, spaced 11 cycles apart.
//    Each res equals the matching A^B.
//  4 A0=8'h01, B0=8'h00, single req -> res=8'h01, parity=1.
//    Then A0=8'hFF, B0=8'h00 -> res=8'hFF, parity=0.
//  5 rst_n=0 for 1 cycle at cycle 5 of an op for req 2 -> next cycle all outputs 0.
//    With req=4'b0101 after reset, req0 is granted first.
//  6 (XOR_SCHED_STATS_EN) run 3 ops -> ops_done=3. Force it to 16'hFFFF, then one op -> 0.

Source files
------------

// File: rtl/xor_sched_pkg.sv
// Shared definitions for the serial XOR scheduler: state encoding and the
// index-width helper used by the top level.
package xor_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_LOAD  = LOAD,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor_bit_cell.sv
// Shared 1-bit XOR cell built from four 2-input NAND primitives.
module xor_bit_cell (
  output logic y,
  input  logic a,
  input  logic b
);

  wire n_ab;
  wire n_a;
  wire n_b;

  nand g_ab (n_ab, a, b);
  nand g_a  (n_a, a, n_ab);
  nand g_b  (n_b, b, n_ab);
  nand g_y  (y, n_a, n_b);

endmodule

// File: rtl/xor_serial_sched.sv
// Round-robin scheduler streaming requester operands LSB-first through one shared
// XOR cell. Optional op counter port ops_done enabled by XOR_SCHED_STATS_EN.
module xor_serial_sched
  import xor_sched_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = 4,
  localparam int IDW = idw(NREQ),
  localparam int CW  = idw(W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [W-1:0]      res,
  output logic [IDW-1:0]    res_id,
  output logic              parity,
`ifdef XOR_SCHED_STATS_EN
  output logic [15:0]       ops_done,
`endif
  output logic [1:0]        dbg_state
);

  // Handshake: req is a level; a request is accepted when its gnt rises, its
  // operands are sampled in that first gnt cycle, and res is valid when done pulses.

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sh;
  logic [CW-1:0]  cnt;

  logic           pick_found;
  logic [IDW-1:0] pick;
  int             idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W-1:0]   sh_next;
  logic           cell_y;

  assign dbg_state = state;

  // Search starts just past the last winner, wrapping modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick       = IDW'(idx);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
  end

  xor_bit_cell u_cell (
    .y (cell_y),
    .a (a_q[cnt]),
    .b (b_q[cnt])
  );

  always_comb begin
    sh_next      = sh;
    sh_next[cnt] = cell_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ptr    <= IDW'(NREQ - 1);
      win    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sh     <= '0;
      cnt    <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= '0;
      res_id <= '0;
      parity <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            win   <= pick;
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          a_q   <= a_sel;
          b_q   <= b_sel;
          sh    <= '0;
          cnt   <= '0;
          ptr   <= win;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          sh  <= sh_next;
          cnt <= cnt + CW'(1);
          // Publish on the last bit so done, res and parity appear together in DONE.
          if (cnt == CW'(W - 1)) begin
            state  <= S_DONE;
            done   <= 1'b1;
            res    <= sh_next;
            res_id <= win;
            parity <= ^sh_next;
          end
        end
        S_DONE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef XOR_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (done) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule
